// File: rtl/sap_microsequencer.sv
// Variable-length microsequencer for the 8-bit SAP bus datapath.
// Optional single-step WAIT state is enabled by defining SEQ_STEP_EN.
module sap_microsequencer #(
    parameter int unsigned T_MAX  = 6,
    parameter logic [3:0]  OP_JMP = 4'b0011,
    parameter logic [3:0]  OP_JZ  = 4'b0100
) (
    input  logic             clk,
    input  logic             clr,
    input  logic [3:0]       op_code,
    input  logic             acc_zero,
    input  logic             step_mode,
    input  logic             step_req,
    output logic             inc,
    output logic             PE,
    output logic             pc_ld,
    output logic             LOW_MAR_LD,
    output logic             LOW_ROM_OE,
    output logic             LOW_IR_LD,
    output logic             LOW_IR_OUT,
    output logic             LOW_ACC_LD,
    output logic             ACC_OE,
    output logic             sub_add,
    output logic             subadd_out_en,
    output logic             LOW_B_LD,
    output logic             LOW_LD_OUT,
    output logic             LOW_HALT,
    output logic             instr_done,
    output logic [T_MAX-1:0] t_state
);

    localparam logic [3:0] OP_LDA = 4'b0000;
    localparam logic [3:0] OP_ADD = 4'b0001;
    localparam logic [3:0] OP_SUB = 4'b0010;
    localparam logic [3:0] OP_OUT = 4'b1110;
    localparam logic [3:0] OP_HLT = 4'b1111;

    // T-states occupy encodings 0..5 so the encoding doubles as the t_state bit index.
    typedef enum logic [2:0] {
        S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_WAIT, S_HALT
    } state_t;

    state_t state, state_next;
    logic   last_step;

    logic is_lda, is_add, is_sub, is_out, is_jmp, is_jz, is_hlt, is_nop;

    assign is_lda = (op_code == OP_LDA);
    assign is_add = (op_code == OP_ADD);
    assign is_sub = (op_code == OP_SUB);
    assign is_out = (op_code == OP_OUT);
    assign is_jmp = (op_code == OP_JMP);
    assign is_jz  = (op_code == OP_JZ);
    assign is_hlt = (op_code == OP_HLT);
    assign is_nop = !(is_lda || is_add || is_sub || is_out || is_jmp || is_jz || is_hlt);

`ifdef SEQ_STEP_EN
    logic req_q;
    logic edge_q;

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            req_q  <= 1'b0;
            edge_q <= 1'b0;
        end else begin
            req_q  <= step_req;
            edge_q <= step_req && !req_q;
        end
    end
`else
    logic unused_step_inputs;
    assign unused_step_inputs = step_mode | step_req;
`endif

    always_ff @(posedge clk or posedge clr) begin
        if (clr) state <= S_T1;
        else     state <= state_next;
    end

    always_comb begin
        state_next = state;
        last_step  = 1'b0;
        case (state)
            S_T1: state_next = S_T2;
            S_T2: state_next = S_T3;
            S_T3: begin
                if (is_nop) last_step  = 1'b1;
                else        state_next = S_T4;
            end
            S_T4: begin
                if (is_lda || is_add || is_sub) state_next = S_T5;
                else if (is_hlt)                state_next = S_HALT;
                else                            last_step  = 1'b1;
            end
            S_T5: begin
                if (is_add || is_sub) state_next = S_T6;
                else                  last_step  = 1'b1;
            end
            S_T6: last_step = 1'b1;
`ifdef SEQ_STEP_EN
            S_WAIT: if (edge_q) state_next = S_T1;
`else
            S_WAIT: state_next = S_T1;
`endif
            S_HALT: state_next = S_HALT;
            default: state_next = S_T1;
        endcase
        if (last_step) begin
`ifdef SEQ_STEP_EN
            state_next = step_mode ? S_WAIT : S_T1;
`else
            state_next = S_T1;
`endif
        end
    end

    // Strobes are gated by clr so an asynchronous reset kills them in the same cycle.
    always_comb begin
        inc           = 1'b0;
        PE            = 1'b0;
        pc_ld         = 1'b0;
        LOW_MAR_LD    = 1'b1;
        LOW_ROM_OE    = 1'b1;
        LOW_IR_LD     = 1'b1;
        LOW_IR_OUT    = 1'b1;
        LOW_ACC_LD    = 1'b1;
        ACC_OE        = 1'b0;
        sub_add       = 1'b0;
        subadd_out_en = 1'b0;
        LOW_B_LD      = 1'b1;
        LOW_LD_OUT    = 1'b1;
        LOW_HALT      = 1'b1;
        instr_done    = 1'b0;
        t_state       = '0;
        for (int unsigned i = 0; i < T_MAX; i++)
            t_state[i] = (32'(state) == i);
        if (!clr) begin
            case (state)
                S_T1: begin
                    PE         = 1'b1;
                    LOW_MAR_LD = 1'b0;
                end
                S_T2: inc = 1'b1;
                S_T3: begin
                    LOW_ROM_OE = 1'b0;
                    LOW_IR_LD  = 1'b0;
                end
                S_T4: begin
                    if (is_lda || is_add || is_sub) begin
                        LOW_IR_OUT = 1'b0;
                        LOW_MAR_LD = 1'b0;
                    end else if (is_out) begin
                        ACC_OE     = 1'b1;
                        LOW_LD_OUT = 1'b0;
                    end else if (is_jmp || (is_jz && acc_zero)) begin
                        LOW_IR_OUT = 1'b0;
                        pc_ld      = 1'b1;
                    end else if (is_hlt) begin
                        LOW_HALT   = 1'b0;
                    end
                end
                S_T5: begin
                    if (is_lda) begin
                        LOW_ROM_OE = 1'b0;
                        LOW_ACC_LD = 1'b0;
                    end else if (is_add || is_sub) begin
                        LOW_ROM_OE = 1'b0;
                        LOW_B_LD   = 1'b0;
                        sub_add    = is_sub;
                    end
                end
                S_T6: begin
                    subadd_out_en = 1'b1;
                    LOW_ACC_LD    = 1'b0;
                    sub_add       = is_sub;
                end
                S_HALT: LOW_HALT = 1'b0;
                default: ;
            endcase
            instr_done = last_step || (state == S_T4 && is_hlt);
        end
    end

`ifndef SYNTHESIS
    bus_exclusive: assert property (@(posedge clk) disable iff (clr)
        $onehot0({PE, !LOW_ROM_OE, !LOW_IR_OUT, ACC_OE, subadd_out_en}));
`endif

endmodule

// File: tb/tb_sap_microsequencer.sv
// Randomized self-checking bench for sap_microsequencer against an instruction-table model.
// Step-mode checks run only when SEQ_STEP_EN is defined.
module tb_sap_microsequencer;

    typedef struct packed {
        logic inc, pe, pc_ld, mar_n, rom_n, irld_n, irout_n, accld_n;
        logic acc_oe, sub_add, alu_oe, bld_n, ldout_n, halt_n, done;
    } strobes_t;

    localparam strobes_t IDLE = '{inc: 1'b0, pe: 1'b0, pc_ld: 1'b0, mar_n: 1'b1,
                                  rom_n: 1'b1, irld_n: 1'b1, irout_n: 1'b1, accld_n: 1'b1,
                                  acc_oe: 1'b0, sub_add: 1'b0, alu_oe: 1'b0, bld_n: 1'b1,
                                  ldout_n: 1'b1, halt_n: 1'b1, done: 1'b0};

    logic       clk = 1'b0;
    logic       clr;
    logic [3:0] op_code;
    logic       acc_zero, step_mode, step_req;
    logic       inc, PE, pc_ld, LOW_MAR_LD, LOW_ROM_OE, LOW_IR_LD, LOW_IR_OUT, LOW_ACC_LD;
    logic       ACC_OE, sub_add, subadd_out_en, LOW_B_LD, LOW_LD_OUT, LOW_HALT, instr_done;
    logic [5:0] t_state;

    int unsigned checks = 0;
    int unsigned failures = 0;

    sap_microsequencer #(.T_MAX(6), .OP_JMP(4'b0011), .OP_JZ(4'b0100)) dut (
        .clk(clk), .clr(clr), .op_code(op_code), .acc_zero(acc_zero),
        .step_mode(step_mode), .step_req(step_req),
        .inc(inc), .PE(PE), .pc_ld(pc_ld), .LOW_MAR_LD(LOW_MAR_LD),
        .LOW_ROM_OE(LOW_ROM_OE), .LOW_IR_LD(LOW_IR_LD), .LOW_IR_OUT(LOW_IR_OUT),
        .LOW_ACC_LD(LOW_ACC_LD), .ACC_OE(ACC_OE), .sub_add(sub_add),
        .subadd_out_en(subadd_out_en), .LOW_B_LD(LOW_B_LD), .LOW_LD_OUT(LOW_LD_OUT),
        .LOW_HALT(LOW_HALT), .instr_done(instr_done), .t_state(t_state)
    );

    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic strobes_t observed();
        strobes_t s;
        s = '{inc: inc, pe: PE, pc_ld: pc_ld, mar_n: LOW_MAR_LD, rom_n: LOW_ROM_OE,
              irld_n: LOW_IR_LD, irout_n: LOW_IR_OUT, accld_n: LOW_ACC_LD, acc_oe: ACC_OE,
              sub_add: sub_add, alu_oe: subadd_out_en, bld_n: LOW_B_LD, ldout_n: LOW_LD_OUT,
              halt_n: LOW_HALT, done: instr_done};
        return s;
    endfunction

    // Number of microsteps an instruction occupies (HLT counted up to its T4).
    function automatic int unsigned instr_len(input logic [3:0] op);
        case (op)
            4'd0:             return 5;
            4'd1, 4'd2:       return 6;
            4'd3, 4'd4, 4'd14, 4'd15: return 4;
            default:          return 3;
        endcase
    endfunction

    function automatic strobes_t expect_step(input int unsigned k, input logic [3:0] op, input logic az);
        strobes_t s;
        s = IDLE;
        case (k)
            1: begin s.pe = 1'b1; s.mar_n = 1'b0; end
            2: s.inc = 1'b1;
            3: begin s.rom_n = 1'b0; s.irld_n = 1'b0; end
            4: case (op)
                   4'd0, 4'd1, 4'd2: begin s.irout_n = 1'b0; s.mar_n = 1'b0; end
                   4'd14: begin s.acc_oe = 1'b1; s.ldout_n = 1'b0; end
                   4'd3:  begin s.irout_n = 1'b0; s.pc_ld = 1'b1; end
                   4'd4:  if (az) begin s.irout_n = 1'b0; s.pc_ld = 1'b1; end
                   4'd15: s.halt_n = 1'b0;
                   default: ;
               endcase
            5: begin
                s.rom_n = 1'b0;
                if (op == 4'd0) s.accld_n = 1'b0;
                else            s.bld_n = 1'b0;
                s.sub_add = (op == 4'd2);
            end
            6: begin s.alu_oe = 1'b1; s.accld_n = 1'b0; s.sub_add = (op == 4'd2); end
            default: ;
        endcase
        s.done = (k == instr_len(op));
        return s;
    endfunction

    task automatic check_cycle(input string tag, input strobes_t exp, input logic [5:0] ts);
        strobes_t o;
        int unsigned drivers;
        o = observed();
        drivers = 32'(o.pe) + 32'(!o.rom_n) + 32'(!o.irout_n) + 32'(o.acc_oe) + 32'(o.alu_oe);
        check({tag, " strobes"}, 32'(o), 32'(exp));
        check({tag, " t_state"}, 32'(t_state), 32'(ts));
        check({tag, " bus"}, 32'(drivers <= 1), 32'd1);
    endtask

    // Entered and left just after a falling edge; checks microsteps first..last.
    task automatic run_steps(input logic [3:0] op, input logic az,
                             input int unsigned first, input int unsigned last);
        op_code = op;
        for (int unsigned k = first; k <= last; k++) begin
            acc_zero = (k == 4) ? az : 1'($urandom);
`ifndef SEQ_STEP_EN
            step_mode = 1'($urandom);
            step_req  = 1'($urandom);
`endif
            #1;
            check_cycle($sformatf("op%0d T%0d", op, k), expect_step(k, op, az), 6'(1 << (k - 1)));
            @(negedge clk);
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic az);
        run_steps(op, az, 1, instr_len(op));
    endtask

    initial begin
        strobes_t halted;
        halted = IDLE;
        halted.halt_n = 1'b0;
        clr = 1'b1; op_code = 4'd0; acc_zero = 1'b0; step_mode = 1'b0; step_req = 1'b0;
        repeat (2) @(negedge clk);
        #1 check("reset strobes", 32'(observed()), 32'(IDLE));
        @(negedge clk);
        clr = 1'b0;

        run_instr(4'd0, 1'b0);
        run_instr(4'd2, 1'b0);
        run_instr(4'd1, 1'b1);
        run_instr(4'd4, 1'b1);
        run_instr(4'd4, 1'b0);
        run_instr(4'd3, 1'b0);
        run_instr(4'd14, 1'b1);
        run_instr(4'd5, 1'b0);
        run_instr(4'd13, 1'b1);

        for (int n = 0; n < 60; n++)
            run_instr(4'($urandom_range(0, 14)), 1'($urandom));

        // Asynchronous clear during T5 of ADD.
        run_steps(4'd1, 1'b0, 1, 4);
        #1 check_cycle("add T5 pre-clr", expect_step(5, 4'd1, 1'b0), 6'b010000);
        #2 clr = 1'b1;
        #1 check("mid clr strobes", 32'(observed()), 32'(IDLE));
        @(negedge clk);
        clr = 1'b0;
        run_instr(4'd1, 1'b0);

        // HLT is sticky until clr.
        run_steps(4'd15, 1'b0, 1, 4);
        for (int n = 0; n < 20; n++) begin
            op_code = 4'($urandom);
            #1 check_cycle($sformatf("halt %0d", n), halted, 6'b000000);
            @(negedge clk);
        end
        #2 clr = 1'b1;
        #1 check("halt clr strobes", 32'(observed()), 32'(IDLE));
        @(negedge clk);
        clr = 1'b0;
        run_instr(4'd0, 1'b0);

`ifdef SEQ_STEP_EN
        begin
            int unsigned t1_seen;
            step_mode = 1'b1;
            step_req  = 1'b0;
            run_instr(4'd14, 1'b0);
            for (int n = 0; n < 3; n++) begin
                #1 check_cycle("wait", IDLE, 6'b000000);
                @(negedge clk);
            end
            t1_seen = 0;
            for (int n = 0; n < 14; n++) begin
                step_req = (n < 5);
                #1 if (t_state == 6'b000001) t1_seen++;
                @(negedge clk);
            end
            check("step one T1", 32'(t1_seen), 32'd1);
            #1 check_cycle("wait again", IDLE, 6'b000000);
            step_mode = 1'b0;
            #2 clr = 1'b1;
            @(negedge clk);
            clr = 1'b0;
            run_instr(4'd2, 1'b0);
        end
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
